// File: rtl/top_level.sv
// Single-cycle datapath slice: 32x64 register file, 64-bit ALU, 256x64 word RAM, write-back mux.
// Optional macro TOPLEVEL_ZERO_REG_EN makes R31 a hard-wired zero register.
module top_level (
   input  logic        clock,
   input  logic        reset,
   input  logic [4:0]  A,
   input  logic [4:0]  B,
   input  logic        wrt,
   input  logic [4:0]  regSel,
   input  logic [63:0] in,
   input  logic        CO,
   input  logic [4:0]  FS,
   output logic [3:0]  SIGNAL,
   input  logic        RAMwrt,
   output logic [63:0] RAMo,
   output logic [63:0] ALUo,
   input  logic        muxSelect
);

   logic [63:0] regs_q [32];
   logic [63:0] mem_q  [256];

   logic [63:0] regAout;
   logic [63:0] regBout;
   logic [63:0] wr_data_d;
   logic        wr_en;

   logic [63:0] op_a;
   logic [63:0] op_b;
   logic [64:0] sum;
   logic        carry;
   logic        ovf;

   // Register file read ports and write qualification
   always_comb begin
`ifdef TOPLEVEL_ZERO_REG_EN
      regAout = (A == 5'd31) ? 64'd0 : regs_q[A];
      regBout = (B == 5'd31) ? 64'd0 : regs_q[B];
      wr_en   = wrt && (regSel != 5'd31);
`else
      regAout = regs_q[A];
      regBout = regs_q[B];
      wr_en   = wrt;
`endif
   end

   always_comb begin
      op_a  = FS[4] ? ~regAout : regAout;
      op_b  = FS[3] ? ~regBout : regBout;
      sum   = {1'b0, op_a} + {1'b0, op_b} + {64'd0, CO};
      carry = 1'b0;
      ovf   = 1'b0;
      ALUo  = 64'd0;
      unique case (FS[2:0])
         3'b000: ALUo = op_a & op_b;
         3'b001: ALUo = op_a | op_b;
         3'b010: begin
            ALUo  = sum[63:0];
            carry = sum[64];
            // Overflow when both operands share a sign the result does not
            ovf   = (op_a[63] == op_b[63]) && (sum[63] != op_a[63]);
         end
         3'b011: ALUo = op_a ^ op_b;
         3'b100: ALUo = op_a << op_b[5:0];
         3'b101: ALUo = op_a >> op_b[5:0];
         3'b110: ALUo = op_a;
         3'b111: ALUo = op_b;
         default: ALUo = 64'd0;
      endcase
      SIGNAL = {ovf, carry, ALUo[63], (ALUo == 64'd0)};
   end

   assign wr_data_d = muxSelect ? ALUo : in;
   assign RAMo      = mem_q[ALUo[7:0]];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= 64'd0;
         end
      end else if (wr_en) begin
         regs_q[regSel] <= wr_data_d;
      end
   end

   // RAM is not cleared by reset; writes still land during reset
   always_ff @(posedge clock) begin
      if (RAMwrt) begin
         mem_q[ALUo[7:0]] <= regBout;
      end
   end

endmodule

// File: tb/tb_top_level.sv
// Randomized self-checking bench for top_level against a behavioural model of the datapath.
// Honors TOPLEVEL_ZERO_REG_EN the same way the design does.
module tb_top_level;

   logic        clock = 1'b0;
   logic        reset;
   logic [4:0]  A, B, regSel, FS;
   logic        wrt, CO, RAMwrt, muxSelect;
   logic [63:0] in;
   logic [3:0]  SIGNAL;
   logic [63:0] RAMo, ALUo;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef TOPLEVEL_ZERO_REG_EN
   localparam bit ZeroReg = 1'b1;
`else
   localparam bit ZeroReg = 1'b0;
`endif

   logic [63:0] m_regs  [32];
   logic [63:0] m_mem   [256];
   bit          m_known [256];

   top_level dut (
      .clock     (clock),
      .reset     (reset),
      .A         (A),
      .B         (B),
      .wrt       (wrt),
      .regSel    (regSel),
      .in        (in),
      .CO        (CO),
      .FS        (FS),
      .SIGNAL    (SIGNAL),
      .RAMwrt    (RAMwrt),
      .RAMo      (RAMo),
      .ALUo      (ALUo),
      .muxSelect (muxSelect)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] m_rd(input logic [4:0] idx);
      if (ZeroReg && idx == 5'd31) return 64'd0;
      return m_regs[idx];
   endfunction

   // Reference ALU from arithmetic definitions: 65-bit unsigned sum for carry, sign-extended sum for V
   function automatic void m_alu(input logic [63:0] ra, input logic [63:0] rb, input logic [4:0] fs,
                                 input logic co, output logic [63:0] res, output logic [3:0] sig);
      logic [63:0]        a, b;
      logic [64:0]        usum;
      logic signed [65:0] ssum;
      bit                 c, v;
      a = fs[4] ? ~ra : ra;
      b = fs[3] ? ~rb : rb;
      c = 0;
      v = 0;
      case (fs[2:0])
         3'd0: res = a & b;
         3'd1: res = a | b;
         3'd2: begin
            usum = 65'(a) + 65'(b) + 65'(co);
            ssum = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b}) + $signed({65'd0, co});
            res  = usum[63:0];
            c    = usum[64];
            v    = (ssum > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (ssum < -66'sh0_8000_0000_0000_0000);
         end
         3'd3: res = a ^ b;
         3'd4: res = a << b[5:0];
         3'd5: res = a >> b[5:0];
         3'd6: res = a;
         default: res = b;
      endcase
      sig = {v, c, res[63], res == 64'd0};
   endfunction

   // Check current combinational outputs, then clock once and advance the model
   task automatic step();
      logic [63:0] ra, rb, res;
      logic [3:0]  sig;
      #1;
      ra = m_rd(A);
      rb = m_rd(B);
      m_alu(ra, rb, FS, CO, res, sig);
      check_eq("regAout", dut.regAout, ra);
      check_eq("regBout", dut.regBout, rb);
      check_eq("ALUo", ALUo, res);
      check_eq("SIGNAL", {60'd0, SIGNAL}, {60'd0, sig});
      if (m_known[res[7:0]]) check_eq("RAMo", RAMo, m_mem[res[7:0]]);
      @(posedge clock);
      if (RAMwrt) begin
         m_mem[res[7:0]]   = rb;
         m_known[res[7:0]] = 1;
      end
      if (reset) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
      end else if (wrt && !(ZeroReg && regSel == 5'd31)) begin
         m_regs[regSel] = muxSelect ? res : in;
      end
      #1;
   endtask

   task automatic wr(input logic [4:0] idx, input logic [63:0] val);
      reset = 0; wrt = 1; muxSelect = 0; regSel = idx; in = val; RAMwrt = 0;
      step();
      wrt = 0;
   endtask

   logic [63:0] specials [6];

   initial begin
      specials = '{64'd0, 64'd1, '1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd63};
      for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
      for (int i = 0; i < 256; i++) m_known[i] = 0;
      reset = 1; wrt = 0; RAMwrt = 0; muxSelect = 0; A = 0; B = 0; regSel = 0;
      FS = 0; CO = 0; in = 0;
      @(posedge clock);
      #1;
      reset = 0;

      #1;
      check_eq("rst_alu", ALUo, 64'd0);
      check_eq("rst_sig", {60'd0, SIGNAL}, 64'd1);

      // Write then read back, then reset clears it
      wr(5, 64'd7364);
      A = 5;
      #1 check_eq("rdback", dut.regAout, 64'd7364);
      reset = 1; wrt = 1; regSel = 5; in = 64'd42;
      step();
      reset = 0; wrt = 0;
      #1 check_eq("rst_clr", dut.regAout, 64'd0);

      wr(1, 64'h7FFF_FFFF_FFFF_FFFF);
      wr(2, 64'd1);
      A = 1; B = 2; FS = 5'b00010; CO = 0;
      #1 check_eq("add_ovf", ALUo, 64'h8000_0000_0000_0000);
      check_eq("add_ovf_sig", {60'd0, SIGNAL}, 64'b1010);
      step();

      wr(1, '1);
      wr(2, '1);
      #1 check_eq("add_cy", ALUo, 64'hFFFF_FFFF_FFFF_FFFE);
      check_eq("add_cy_c", {63'd0, SIGNAL[2]}, 64'd1);
      step();

      wr(1, 64'd10);
      wr(2, 64'd10);
      FS = 5'b01010; CO = 1;
      #1 check_eq("sub", ALUo, 64'd0);
      check_eq("sub_sig", {60'd0, SIGNAL}, 64'b0101);
      step();

      wr(1, 64'd1);
      wr(2, 64'd63);
      FS = 5'b00100; CO = 0;
      #1 check_eq("shl63", ALUo, 64'h8000_0000_0000_0000);
      FS = 5'b00101;
      #1 check_eq("shr63", ALUo, 64'd0);
      step();
      wr(2, 64'd0);
      FS = 5'b10000;
      #1 check_eq("nand0", ALUo, 64'd0);
      step();

      // Memory path and ALU write-back
      wr(3, 64'h1234);
      wr(1, 64'd5);
      A = 1; B = 3; FS = 5'b00110; RAMwrt = 1;
      step();
      RAMwrt = 0;
      #1 check_eq("ram_rd", RAMo, 64'h1234);
      muxSelect = 1; regSel = 7; wrt = 1;
      step();
      wrt = 0; muxSelect = 0; A = 7;
      #1 check_eq("wb_alu", dut.regAout, 64'd5);

      wr(31, 64'd99);
      A = 31;
`ifdef TOPLEVEL_ZERO_REG_EN
      #1 check_eq("r31_zero", dut.regAout, 64'd0);
`else
      #1 check_eq("r31_plain", dut.regAout, 64'd99);
`endif
      step();

      for (int n = 0; n < 600; n++) begin
         reset     = ($urandom_range(0, 63) == 0);
         A         = 5'($urandom);
         B         = 5'($urandom);
         wrt       = ($urandom_range(0, 1) == 1);
         regSel    = 5'($urandom);
         muxSelect = ($urandom_range(0, 3) == 0);
         CO        = 1'($urandom);
         FS        = 5'($urandom);
         RAMwrt    = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 1) == 1) in = specials[$urandom_range(0, 5)];
         else in = {$urandom, $urandom};
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
